// File: rtl/count_sync_monitor_if.sv
// -----------------------------------------------------------------------------
// count_sync_monitor_if
// Purpose : groups the count bus, the error-clear strobe and all monitor
//           results into one bundle shared by the count monitor and its user.
// Signals :
//   count_in   raw count from the ripple counter, asynchronous to clk
//   err_clr    synchronous pulse, clears err_sticky
//   count_q    last accepted (filtered) count
//   valid      high once the first value has been accepted after reset
//   upd        one-cycle pulse on every accept
//   step_up    one-cycle pulse, accepted value = previous + 1
//   step_down  one-cycle pulse, accepted value = previous - 1
//   wrap       one-cycle pulse on an F->0 or 0->F transition
//   skip_err   one-cycle pulse on any other nonzero change
//   err_sticky set by skip_err, cleared by err_clr
//   err_cnt    saturating count of skip_err events
//   seg        registered {g,f,e,d,c,b,a} hex pattern of count_q
// Modports: master = count source / result consumer, slave = the monitor.
// -----------------------------------------------------------------------------
interface count_sync_monitor_if #(
  parameter int W     = 4,
  parameter int ERR_W = 8
);
  logic [W-1:0]     count_in;
  logic             err_clr;
  logic [W-1:0]     count_q;
  logic             valid;
  logic             upd;
  logic             step_up;
  logic             step_down;
  logic             wrap;
  logic             skip_err;
  logic             err_sticky;
  logic [ERR_W-1:0] err_cnt;
  logic [6:0]       seg;

  modport master (
    output count_in, err_clr,
    input  count_q, valid, upd, step_up, step_down, wrap, skip_err,
           err_sticky, err_cnt, seg
  );

  modport slave (
    input  count_in, err_clr,
    output count_q, valid, upd, step_up, step_down, wrap, skip_err,
           err_sticky, err_cnt, seg
  );
endinterface

// File: rtl/count_sync_monitor.sv
// -----------------------------------------------------------------------------
// count_sync_monitor
// Purpose : consumes the glitchy, asynchronous count bus of a 4-bit ripple
//           up/down counter. The bus is synchronised through two flops, a
//           value is accepted only after it has been seen unchanged for
//           STABLE_CYCLES consecutive samples, every accepted change is
//           classified (up step, down step, wrap, skip error) and the accepted
//           value is shown as a registered hex 7-segment pattern.
// Ports   :
//   clk     single clock, all flops rising edge
//   resetb  asynchronous active-low reset
//   bus     count_sync_monitor_if.slave (count_in/err_clr in, results out)
// Parameters:
//   W              count width (segment decode and wrap rules assume 4)
//   STABLE_CYCLES  equal synced samples required before accepting (>= 1)
//   ERR_W          width of the saturating skip-error counter
//   SEG_ACTIVE_LOW 1: segment lit when its bit is 0; 0: lit when 1
// -----------------------------------------------------------------------------
module count_sync_monitor #(
  parameter int W              = 4,
  parameter int STABLE_CYCLES  = 3,
  parameter int ERR_W          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetb,
  count_sync_monitor_if.slave   bus
);

  localparam int STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_ONE  = STAB_W'(1);
  localparam logic [W-1:0]      CNT_ZERO  = {W{1'b0}};
  localparam logic [W-1:0]      CNT_ONE   = W'(1);
  localparam logic [W-1:0]      CNT_MAX   = {W{1'b1}};
  localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [6:0]        SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  // Active-high {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex_pattern(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'h0:    p = 7'h3F;
      4'h1:    p = 7'h06;
      4'h2:    p = 7'h5B;
      4'h3:    p = 7'h4F;
      4'h4:    p = 7'h66;
      4'h5:    p = 7'h6D;
      4'h6:    p = 7'h7D;
      4'h7:    p = 7'h07;
      4'h8:    p = 7'h7F;
      4'h9:    p = 7'h6F;
      4'hA:    p = 7'h77;
      4'hB:    p = 7'h7C;
      4'hC:    p = 7'h39;
      4'hD:    p = 7'h5E;
      4'hE:    p = 7'h79;
      4'hF:    p = 7'h71;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Pattern with the configured drive polarity applied.
  function automatic logic [6:0] seg_drive(input logic [3:0] v);
    return SEG_ACTIVE_LOW ? ~hex_pattern(v) : hex_pattern(v);
  endfunction

  state_e            state_q, state_d;
  logic [W-1:0]      sync1_q, sync2_q;
  logic [W-1:0]      cand_q, cand_d;
  logic [STAB_W-1:0] stab_q, stab_d;
  logic [W-1:0]      acc_q, acc_d;
  logic              valid_q, valid_d;
  logic              upd_q, upd_d;
  logic              step_up_q, step_up_d;
  logic              step_down_q, step_down_d;
  logic              wrap_q, wrap_d;
  logic              skip_err_q, skip_err_d;
  logic              err_sticky_q, err_sticky_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [6:0]        seg_q, seg_d;
  logic              accept_s;
  logic [W-1:0]      delta_s;
  logic              is_wrap_s;

  // Filter, FSM next state and registered result/pulse values.
  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    stab_d       = stab_q;
    acc_d        = acc_q;
    valid_d      = valid_q;
    upd_d        = 1'b0;
    step_up_d    = 1'b0;
    step_down_d  = 1'b0;
    wrap_d       = 1'b0;
    skip_err_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    seg_d        = seg_q;
    accept_s     = 1'b0;
    // Delta is taken against the value being replaced, before the update.
    delta_s      = cand_q - acc_q;
    is_wrap_s    = ((acc_q == CNT_MAX) && (cand_q == CNT_ZERO)) ||
                   ((acc_q == CNT_ZERO) && (cand_q == CNT_MAX));

    // Any change of the synced value restarts the stability window, so a
    // value that is still settling can never be accepted.
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      stab_d = {STAB_W{1'b0}};
    end else if ((stab_q == STAB_LAST) &&
                 ((state_q == ST_INIT) || (cand_q != acc_q))) begin
      accept_s = 1'b1;
    end else if (stab_q < STAB_LAST) begin
      stab_d = stab_q + STAB_ONE;
    end else begin
      stab_d = stab_q;
    end

    if (accept_s) begin
      acc_d = cand_q;
      seg_d = seg_drive(cand_q[3:0]);
      upd_d = 1'b1;
      case (state_q)
        ST_INIT: begin
          // First value after reset only establishes the baseline.
          valid_d = 1'b1;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          wrap_d = is_wrap_s;
          if (delta_s == CNT_ONE) begin
            step_up_d = 1'b1;
          end else if (delta_s == CNT_MAX) begin
            step_down_d = 1'b1;
          end else begin
            skip_err_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_INIT;
        end
      endcase
    end else begin
      acc_d = acc_q;
    end

    // A new error on the same edge as err_clr keeps the flag set.
    if (skip_err_d) begin
      err_sticky_d = 1'b1;
    end else if (bus.err_clr) begin
      err_sticky_d = 1'b0;
    end else begin
      err_sticky_d = err_sticky_q;
    end

    if (skip_err_d && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_ONE;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Two-flop synchroniser, filter state, FSM state and registered outputs.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_INIT;
      sync1_q      <= {W{1'b0}};
      sync2_q      <= {W{1'b0}};
      cand_q       <= {W{1'b0}};
      stab_q       <= {STAB_W{1'b0}};
      acc_q        <= {W{1'b0}};
      valid_q      <= 1'b0;
      upd_q        <= 1'b0;
      step_up_q    <= 1'b0;
      step_down_q  <= 1'b0;
      wrap_q       <= 1'b0;
      skip_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= {ERR_W{1'b0}};
      seg_q        <= SEG_OFF;
    end else begin
      state_q      <= state_d;
      sync1_q      <= bus.count_in;
      sync2_q      <= sync1_q;
      cand_q       <= cand_d;
      stab_q       <= stab_d;
      acc_q        <= acc_d;
      valid_q      <= valid_d;
      upd_q        <= upd_d;
      step_up_q    <= step_up_d;
      step_down_q  <= step_down_d;
      wrap_q       <= wrap_d;
      skip_err_q   <= skip_err_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
      seg_q        <= seg_d;
    end
  end

  assign bus.count_q    = acc_q;
  assign bus.valid      = valid_q;
  assign bus.upd        = upd_q;
  assign bus.step_up    = step_up_q;
  assign bus.step_down  = step_down_q;
  assign bus.wrap       = wrap_q;
  assign bus.skip_err   = skip_err_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.seg        = seg_q;

endmodule

// File: tb/tb_count_sync_monitor.sv
// -----------------------------------------------------------------------------
// tb_count_sync_monitor
// Directed bench for count_sync_monitor (STABLE_CYCLES=3, ERR_W=2, active-low
// segments). Each applied value pushes its hand-computed expected result and
// the cycle it must appear on into a queue; an independent monitor pops and
// compares whenever the DUT pulses upd, and flags stray pulses otherwise.
// -----------------------------------------------------------------------------
module tb_count_sync_monitor;

  typedef struct {
    logic [3:0] val;
    logic       up;
    logic       dn;
    logic       wr;
    logic       sk;
    logic       st;
    logic [1:0] ecnt;
    int         cyc;
  } exp_t;

  logic clk;
  logic resetb;
  int   cyc;
  int   total;
  int   bad;
  exp_t exp_q[$];
  exp_t cur;

  count_sync_monitor_if #(.W(4), .ERR_W(2)) bus ();

  count_sync_monitor #(
    .W(4),
    .STABLE_CYCLES(3),
    .ERR_W(2),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .resetb(resetb),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-written active-low {g,f,e,d,c,b,a} patterns.
  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] v, input logic up, input logic dn,
                          input logic wr, input logic sk, input logic st,
                          input logic [1:0] ecnt, input int at_cyc);
    exp_t e;
    e.val = v; e.up = up; e.dn = dn; e.wr = wr; e.sk = sk; e.st = st;
    e.ecnt = ecnt; e.cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  // Drive a new count and hold it; optionally pulse err_clr on the accept edge.
  task automatic apply(input logic [3:0] v, input logic clr, input logic up,
                       input logic dn, input logic wr, input logic sk,
                       input logic st, input logic [1:0] ecnt);
    @(negedge clk);
    bus.count_in = v;
    push_exp(v, up, dn, wr, sk, st, ecnt, cyc + 6);
    if (clr) begin
      repeat (5) @(negedge clk);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_count_q"}, int'(bus.count_q), 0);
    check({tag, "_valid"}, int'(bus.valid), 0);
    check({tag, "_upd"}, int'(bus.upd), 0);
    check({tag, "_pulses"},
          int'({bus.step_up, bus.step_down, bus.wrap, bus.skip_err}), 0);
    check({tag, "_sticky"}, int'(bus.err_sticky), 0);
    check({tag, "_err_cnt"}, int'(bus.err_cnt), 0);
    check({tag, "_seg"}, int'(bus.seg), int'(7'h7F));
  endtask

  // Scoreboard monitor: compare on every upd, require silence otherwise.
  always @(negedge clk) begin
    if (resetb) begin
      if (bus.upd) begin
        if (exp_q.size() == 0) begin
          total = total + 1;
          bad = bad + 1;
          $display("FAIL unexpected_upd actual=1 expected=0 count_q=%0d cyc=%0d",
                   bus.count_q, cyc);
        end else begin
          cur = exp_q.pop_front();
          check("upd_cycle", cyc, cur.cyc);
          check("count_q", int'(bus.count_q), int'(cur.val));
          check("valid", int'(bus.valid), 1);
          check("step_up", int'(bus.step_up), int'(cur.up));
          check("step_down", int'(bus.step_down), int'(cur.dn));
          check("wrap", int'(bus.wrap), int'(cur.wr));
          check("skip_err", int'(bus.skip_err), int'(cur.sk));
          check("err_sticky", int'(bus.err_sticky), int'(cur.st));
          check("err_cnt", int'(bus.err_cnt), int'(cur.ecnt));
          check("seg", int'(bus.seg), int'(seg_ref(cur.val)));
        end
      end else begin
        check("idle_pulses",
              int'({bus.step_up, bus.step_down, bus.wrap, bus.skip_err}), 0);
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    resetb = 1'b0;
    bus.count_in = 4'h5;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset("rst");

    // T1: first value after reset is accepted with no classification.
    @(negedge clk);
    resetb = 1'b1;
    push_exp(4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, cyc + 6);
    repeat (10) @(negedge clk);

    // T2 up, then T4 short glitch, then T2 down and further down steps.
    apply(4'h6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    bus.count_in = 4'h7;
    repeat (2) @(negedge clk);
    bus.count_in = 4'h6;
    repeat (10) @(negedge clk);
    check("glitch_count_q", int'(bus.count_q), 6);
    check("glitch_seg", int'(bus.seg), int'(7'b0000010));
    apply(4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    apply(4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    apply(4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

    // T5: skip error, then err_clr alone, then err_clr on an error edge.
    apply(4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);
    @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("clr_sticky", int'(bus.err_sticky), 0);
    check("clr_keeps_cnt", int'(bus.err_cnt), 1);
    apply(4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2);

    // T3: wraps in both directions.
    apply(4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2);
    apply(4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);

    // T5 continued: counter saturates at 3 with ERR_W=2.
    apply(4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
    apply(4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3);
    apply(4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3);

    // T6: reset in the middle of B's stability window.
    @(negedge clk);
    bus.count_in = 4'hB;
    repeat (3) @(negedge clk);
    #2;
    resetb = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(negedge clk);
    resetb = 1'b1;
    push_exp(4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, cyc + 6);
    repeat (10) @(negedge clk);
    apply(4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    apply(4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1);

    for (int i = 0; (i < 50) && (exp_q.size() != 0); i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
